// File: rtl/display_code_encoder.sv
// display_code_encoder: binary timer value -> four 4-bit digit codes, scanned onto one display_decoder
// Ports: clock/reset (sync, active-high); start/value/error_in request a conversion;
//   busy (converting), done (one-cycle pulse when codes updates), codes (four digit nibbles,
//   [15:12] thousands .. [3:0] units), digit_code/digit_enable (registered scan outputs,
//   digit_enable active-low one-hot).
// Optional macro LEADING_ZERO_BLANK_EN: blanks leading zero digits of numeric results.
module display_code_encoder #(
    parameter int WIDTH     = 14,
    parameter int MAX_VALUE = 9999,
    parameter int SCAN_DIV  = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             error_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      codes,
    output logic [3:0]       digit_code,
    output logic [3:0]       digit_enable
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    localparam int SW = $clog2(SCAN_DIV + 1);
    state_t state, state_n;
    logic [WIDTH-1:0] shreg;
    logic [15:0] bcd, adj, bcd_n;
    logic [4:0] cnt;
    logic [3:0] blank, blank_n;
    logic [SW-1:0] scnt;
    logic [1:0] idx;
    logic bad, last, wrap;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
        bcd_n = {adj[14:0], shreg[WIDTH-1]};
        bad = error_in || 32'(value) > MAX_VALUE;
        last = cnt == 5'(WIDTH - 1);
        wrap = scnt == SW'(SCAN_DIV - 1);
        state_n = state == IDLE ? (start ? (bad ? DONE : CONVERT) : IDLE) :
                  state == CONVERT ? (last ? DONE : CONVERT) : IDLE;
        busy = state == CONVERT;
        done = state == DONE;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank when it and every digit above it is zero; units always shown.
        blank_n[3] = bcd_n[15:12] == 4'd0;
        blank_n[2] = blank_n[3] && bcd_n[11:8] == 4'd0;
        blank_n[1] = blank_n[2] && bcd_n[7:4] == 4'd0;
        blank_n[0] = 1'b0;
`else
        blank_n = 4'b0000;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bcd          <= '0;
            cnt          <= '0;
            codes        <= '0;
            blank        <= '0;
            scnt         <= '0;
            idx          <= '0;
            digit_enable <= 4'b1110;
            digit_code   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                if (bad) begin
                    codes <= 16'hCEEF;
                    blank <= '0;
                end else begin
                    shreg <= value;
                    bcd   <= '0;
                    cnt   <= '0;
                end
            end
            if (state == CONVERT) begin
                bcd   <= bcd_n;
                shreg <= shreg << 1;
                cnt   <= cnt + 5'd1;
                // Publish only the finished result so the display never shows partial digits.
                if (last) begin
                    codes <= bcd_n;
                    blank <= blank_n;
                end
            end
            scnt         <= wrap ? '0 : scnt + SW'(1);
            idx          <= idx + 2'(wrap);
            digit_enable <= ~(4'b0001 << idx) | {4{blank[idx]}};
            digit_code   <= codes[4*idx+:4];
        end
    end
endmodule

// File: tb/tb_display_code_encoder.sv
// tb_display_code_encoder: directed + random checks of display_code_encoder against a decimal model
module tb_display_code_encoder;
    logic clk = 0, rst = 1, start = 0, error_in = 0;
    logic [13:0] value = 0;
    logic busy, done;
    logic [15:0] codes;
    logic [3:0] digit_code, digit_enable;
    int checks = 0, errors = 0, n = 0;
    logic [15:0] exp_codes;
    int exp_v;
    bit exp_num;

    display_code_encoder #(.WIDTH(14), .MAX_VALUE(9999), .SCAN_DIV(4)) dut (
        .clock(clk), .reset(rst), .start(start), .value(value), .error_in(error_in),
        .busy(busy), .done(done), .codes(codes), .digit_code(digit_code),
        .digit_enable(digit_enable));

    always #5 clk = ~clk;
    always @(posedge clk) n <= rst ? 0 : n + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model(input int v, input bit e);
        if (e || v > 9999) return 16'hCEEF;
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Start a conversion, optionally pulsing start again at cycle 'again', and check timing and result.
    task automatic run(input int v, input bit e, input int again);
        int cyc, nb;
        bit numeric;
        numeric = !(e || v > 9999);
        @(negedge clk);
        start = 1; value = 14'(v); error_in = e;
        @(negedge clk);
        start = 0; value = 14'($urandom); error_in = 1'($urandom);
        cyc = 1; nb = 0;
        while (!done && cyc < 40) begin
            if (busy) nb++;
            start = cyc == again;
            @(negedge clk);
            cyc++;
        end
        start = 0;
        exp_codes = model(v, e); exp_v = v; exp_num = numeric;
        chk($sformatf("done_cycle v=%0d e=%0d", v, e), cyc, numeric ? 15 : 1);
        chk($sformatf("busy_cycles v=%0d", v), nb, numeric ? 14 : 0);
        chk($sformatf("codes v=%0d e=%0d", v, e), codes, exp_codes);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    // Scan position follows elapsed clocks since reset; registered outputs lag the index by one clock.
    task automatic scan(input int cycles);
        int pos;
        logic [3:0] en;
        repeat (2) @(negedge clk);
        for (int k = 0; k < cycles; k++) begin
            pos = n == 0 ? 0 : ((n - 1) / 4) % 4;
            en = ~(4'b0001 << pos);
`ifdef LEADING_ZERO_BLANK_EN
            if (exp_num && pos > 0 && exp_v < 10 ** pos) en = 4'b1111;
`endif
            chk($sformatf("digit_enable n=%0d", n), digit_enable, en);
            chk($sformatf("digit_code n=%0d", n), digit_code, exp_codes[4*pos+:4]);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_codes", codes, 16'h0000);
        chk("reset_enable", digit_enable, 4'b1110);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_codes", codes, 16'h0000);
        run(1234, 0, 0);
        scan(20);
        run(10000, 0, 0);
        run(5, 1, 0);
        run(9999, 0, 0);
        run(0, 0, 0);
        scan(16);
        run(42, 0, 3);
        repeat (3) @(negedge clk);
        chk("no_queued_start", done | busy, 0);
        scan(16);
        @(negedge clk);
        start = 1; value = 14'd777; error_in = 0;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_codes", codes, 16'h0000);
        repeat (20) @(negedge clk);
        chk("midreset_no_resume", codes, 16'h0000);
        for (int i = 0; i < 25; i++)
            run(int'($urandom_range(0, 16383)), $urandom_range(0, 7) == 0, 0);
        scan(8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
